// File: rtl/sram_ctl_if.sv
// Wishbone B4 pipelined bus bundle between an interconnect master and sram_ctl.
// Clock and reset are not part of the bundle; they stay plain ports.
interface sram_ctl_if #(
  parameter int WB_ADDR_W = 17,
  parameter int DATA_W    = 8
);
  logic [WB_ADDR_W-1:0] wb_addr_i;
  logic [DATA_W-1:0]    wb_data_i;
  logic [DATA_W-1:0]    wb_data_o;
  logic                 wb_we_i;
  logic                 wb_cycle_i;
  logic                 wb_strobe_i;
  logic                 wb_stall_o;
  logic                 wb_ack_o;

  modport master (
    output wb_addr_i, wb_data_i, wb_we_i, wb_cycle_i, wb_strobe_i,
    input  wb_data_o, wb_stall_o, wb_ack_o
  );

  modport slave (
    input  wb_addr_i, wb_data_i, wb_we_i, wb_cycle_i, wb_strobe_i,
    output wb_data_o, wb_stall_o, wb_ack_o
  );
endinterface

// File: rtl/sram_ctl.sv
// sram_ctl: Wishbone B4 pipelined slave in front of an asynchronous SRAM.
// One access at a time: IDLE -> READ | WRITE -> RECOVER -> IDLE, with
// cycle-count timing for the OE window, the WE pulse and the read turnaround.
// Optional feature macro: SRAM_CTL_RDCACHE_EN adds a one-entry read cache
// (tagged by SRAM address) that answers repeat reads without an SRAM access.
module sram_ctl #(
  parameter int WB_ADDR_W  = 17,
  parameter int RAM_ADDR_W = 17,
  parameter int DATA_W     = 8,
  parameter int BASE_W     = 0,
  parameter int BASE       = 0,
  parameter int RD_CYCLES  = 4,
  parameter int WR_CYCLES  = 3,
  parameter int TA_CYCLES  = 1
) (
  input  logic                  wb_clock_i,
  input  logic                  wb_reset_ni,
  sram_ctl_if.slave             wb,
  output logic [RAM_ADDR_W-1:0] ram_addr_o,
  output logic                  ram_oe_o,
  output logic                  ram_we_o,
  input  logic [DATA_W-1:0]     ram_data_i,
  output logic [DATA_W-1:0]     ram_data_o,
  output logic                  ram_data_oe
);

  localparam int MAX_RW  = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int MAX_CYC = (MAX_RW > TA_CYCLES) ? MAX_RW : TA_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_CYCLES - 1);
  localparam logic [CNT_W-1:0] TA_LAST = CNT_W'(TA_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_RECOVER,
    S_HIT
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] rec_last;  // last count of the current RECOVER stay
  logic             wr_abort;  // cycle dropped at some point during the WE pulse
  logic             sel;
  logic             req;
  logic             hit;

  // Address window decode; a zero-width select field means always selected.
  if (BASE_W == 0) begin : g_no_sel
    assign sel = 1'b1;
  end else begin : g_sel
    assign sel = (wb.wb_addr_i[WB_ADDR_W-1 -: BASE_W] == BASE_W'(BASE));
  end

  assign req = sel & wb.wb_cycle_i & wb.wb_strobe_i;

  // NOTE: stall is decoded straight from the state register so the master sees
  // it in the same cycle; only IDLE can take a new request.
  assign wb.wb_stall_o = (state != S_IDLE);

  // The FPGA drives the SRAM data pins exactly while the write pulse is active.
  assign ram_data_oe = ram_we_o;

`ifdef SRAM_CTL_RDCACHE_EN
  logic                  c_valid;
  logic [RAM_ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0]     c_data;

  assign hit = c_valid && !wb.wb_we_i && (c_addr == wb.wb_addr_i[RAM_ADDR_W-1:0]);
`else
  assign hit = 1'b0;
`endif

  // Access sequencer: state, timing counter, registered bus and SRAM outputs.
  // NOTE: every register here uses non-blocking assignment so all of them
  // update together on the edge; reset is synchronous (sampled on the edge).
  always_ff @(posedge wb_clock_i) begin
    if (!wb_reset_ni) begin
      state        <= S_IDLE;
      cnt          <= '0;
      rec_last     <= '0;
      wr_abort     <= 1'b0;
      wb.wb_ack_o  <= 1'b0;
      wb.wb_data_o <= '0;
      ram_addr_o   <= '0;
      ram_data_o   <= '0;
      ram_oe_o     <= 1'b0;
      ram_we_o     <= 1'b0;
`ifdef SRAM_CTL_RDCACHE_EN
      c_valid      <= 1'b0;
      c_addr       <= '0;
      c_data       <= '0;
`endif
    end else begin
      wb.wb_ack_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            cnt <= '0;
            if (hit) begin
              state <= S_HIT;
            end else begin
              ram_addr_o <= wb.wb_addr_i[RAM_ADDR_W-1:0];
              wr_abort   <= 1'b0;
              if (wb.wb_we_i) begin
                ram_data_o <= wb.wb_data_i;
                ram_we_o   <= 1'b1;
                state      <= S_WRITE;
              end else begin
                ram_oe_o <= 1'b1;
                state    <= S_READ;
              end
            end
          end
        end

        S_READ: begin
          if (!wb.wb_cycle_i) begin
            // Abort: release the SRAM at once, still honour the turnaround.
            ram_oe_o <= 1'b0;
            cnt      <= '0;
            rec_last <= TA_LAST;
            state    <= S_RECOVER;
          end else if (cnt == RD_LAST) begin
            wb.wb_data_o <= ram_data_i;
            wb.wb_ack_o  <= 1'b1;
            ram_oe_o     <= 1'b0;
            cnt          <= '0;
            rec_last     <= TA_LAST;
            state        <= S_RECOVER;
`ifdef SRAM_CTL_RDCACHE_EN
            c_valid      <= 1'b1;
            c_addr       <= ram_addr_o;
            c_data       <= ram_data_i;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_WRITE: begin
          // A write is never truncated; an abort only suppresses the ack.
          if (cnt == WR_LAST) begin
            ram_we_o <= 1'b0;
            cnt      <= '0;
            rec_last <= '0;
            state    <= S_RECOVER;
            if (wb.wb_cycle_i && !wr_abort) begin
              wb.wb_ack_o <= 1'b1;
`ifdef SRAM_CTL_RDCACHE_EN
              c_valid     <= 1'b1;
              c_addr      <= ram_addr_o;
              c_data      <= ram_data_o;
            end else begin
              c_valid     <= 1'b0;
`endif
            end
          end else begin
            cnt      <= cnt + 1'b1;
            wr_abort <= wr_abort | !wb.wb_cycle_i;
          end
        end

        S_RECOVER: begin
          if (cnt == rec_last) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_HIT: begin
          // Cached read: answer one cycle after acceptance, no SRAM activity.
          state <= S_IDLE;
`ifdef SRAM_CTL_RDCACHE_EN
          if (wb.wb_cycle_i) begin
            wb.wb_ack_o  <= 1'b1;
            wb.wb_data_o <= c_data;
          end
`endif
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctl.sv
// Testbench for sram_ctl: randomized and directed Wishbone traffic against a
// behavioural SRAM, with a scoreboard queue of expected acks checked by an
// independent monitor, plus an SRAM pin-protocol monitor.
`timescale 1ns/1ps
module tb_sram_ctl;
  localparam int AW = 17;
  localparam int DW = 8;
  localparam int RD = 4;
  localparam int WR = 3;
  localparam int TA = 1;
`ifdef SRAM_CTL_RDCACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (default parameters) ----------------
  sram_ctl_if #(.WB_ADDR_W(AW), .DATA_W(DW)) wb ();
  logic [AW-1:0] ram_addr;
  logic          ram_oe, ram_we, ram_doe;
  logic [DW-1:0] ram_din, ram_dout;

  sram_ctl #(.WB_ADDR_W(AW), .RAM_ADDR_W(AW), .DATA_W(DW),
             .RD_CYCLES(RD), .WR_CYCLES(WR), .TA_CYCLES(TA)) dut (
    .wb_clock_i (clk),
    .wb_reset_ni(rst_n),
    .wb         (wb),
    .ram_addr_o (ram_addr),
    .ram_oe_o   (ram_oe),
    .ram_we_o   (ram_we),
    .ram_data_i (ram_din),
    .ram_data_o (ram_dout),
    .ram_data_oe(ram_doe)
  );

  // ---------------- second DUT with an address window ----------------
  sram_ctl_if #(.WB_ADDR_W(AW), .DATA_W(DW)) wb2 ();
  logic [AW-1:0] ram2_addr;
  logic          ram2_oe, ram2_we, ram2_doe;
  logic [DW-1:0] ram2_dout;

  sram_ctl #(.BASE_W(2), .BASE(1)) dut2 (
    .wb_clock_i (clk),
    .wb_reset_ni(rst_n),
    .wb         (wb2),
    .ram_addr_o (ram2_addr),
    .ram_oe_o   (ram2_oe),
    .ram_we_o   (ram2_we),
    .ram_data_i (8'h3C),
    .ram_data_o (ram2_dout),
    .ram_data_oe(ram2_doe)
  );

  // ---------------- behavioural asynchronous SRAM ----------------
  function automatic logic [7:0] init_val(input int a);
    if (a == 'h01234) return 8'hA5;
    return 8'((a * 37) ^ (a >> 8) ^ 'h5C);
  endfunction

  logic [DW-1:0] sram [0:(1<<AW)-1];
  initial begin
    for (int i = 0; i < (1 << AW); i++) sram[i] = init_val(i);
    forever begin
      @(negedge clk);
      if (ram_we) sram[ram_addr] = ram_dout;
    end
  end
  assign ram_din = ram_oe ? sram[ram_addr] : 8'hEE;

  // ---------------- reference model and scoreboard ----------------
  logic [7:0] ref_mem [int];
  bit         c_valid = 1'b0;
  int         c_addr  = 0;

  function automatic logic [7:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  typedef struct {
    bit         we;
    logic [7:0] data;
    int         acc;  // cycle number of the accepting edge
    int         lat;  // expected edges from accept to ack
  } exp_t;
  exp_t sb[$];

  int checks  = 0;
  int errors  = 0;
  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Ack monitor: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (wb.wb_ack_o) begin
      if (sb.size() == 0) begin
        check("ack_without_request", wb.wb_ack_o, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ack_latency", cyc_cnt - e.acc, e.lat);
        if (!e.we) check("read_data", wb.wb_data_o, e.data);
      end
    end
  end

  // SRAM pin monitor: WE width, WE/OE separation, address/data stability.
  int  we_len = 0, oe_low = 100, oe_rises = 0;
  bit  prev_we = 1'b0, prev_oe = 1'b0, prev_act = 1'b0, moved = 1'b0, doe_bad = 1'b0;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_data;
  always @(negedge clk) begin
    if (ram_we && !prev_we) begin
      check("we_while_oe", ram_oe, 1'b0);
      check("we_turnaround_after_oe", oe_low > TA, 1'b1);
    end
    if (ram_oe && !prev_oe) oe_rises++;
    if (ram_doe !== ram_we) doe_bad = 1'b1;
    if (ram_we) we_len++;
    if (!ram_we && prev_we) begin
      check("we_width", we_len, WR);
      check("data_oe_tracks_we", doe_bad, 1'b0);
      we_len  = 0;
      doe_bad = 1'b0;
    end
    if ((ram_oe || ram_we) && prev_act &&
        (ram_addr != p_addr || (ram_we && ram_dout != p_data))) moved = 1'b1;
    if (!(ram_oe || ram_we) && prev_act) begin
      check("addr_data_stable", moved, 1'b0);
      moved = 1'b0;
    end
    oe_low   = ram_oe ? 0 : oe_low + 1;
    prev_we  = ram_we;
    prev_oe  = ram_oe;
    prev_act = ram_oe || ram_we;
    p_addr   = ram_addr;
    p_data   = ram_dout;
  end

  // Driver: called at a negedge; returns at the negedge after the accept edge.
  // expect_ack=0 marks an access the test will abort or reset.
  task automatic do_req(input bit we, input logic [AW-1:0] a, input logic [7:0] d,
                        input bit expect_ack);
    exp_t e;
    int   n = 0;
    while (wb.wb_stall_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) check("stall_release_timeout", wb.wb_stall_o, 1'b0);
    wb.wb_addr_i   = a;
    wb.wb_data_i   = d;
    wb.wb_we_i     = we;
    wb.wb_cycle_i  = 1'b1;
    wb.wb_strobe_i = 1'b1;
    e.we  = we;
    e.acc = cyc_cnt + 1;
    if (we) begin
      e.data = d;
      e.lat  = WR;
      ref_mem[int'(a)] = d;  // aborted writes still complete on the SRAM
      c_valid = expect_ack;
      c_addr  = int'(a);
    end else begin
      e.data = ref_rd(int'(a));
      e.lat  = (CACHE && c_valid && c_addr == int'(a)) ? 1 : RD;
      if (expect_ack) begin
        c_valid = 1'b1;
        c_addr  = int'(a);
      end
    end
    if (expect_ack) sb.push_back(e);
    @(negedge clk);
    wb.wb_strobe_i = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] a;
    int            got, seen, t0;

    wb.wb_addr_i = '0; wb.wb_data_i = '0; wb.wb_we_i = 1'b0;
    wb.wb_cycle_i = 1'b0; wb.wb_strobe_i = 1'b0;
    wb2.wb_addr_i = '0; wb2.wb_data_i = '0; wb2.wb_we_i = 1'b0;
    wb2.wb_cycle_i = 1'b0; wb2.wb_strobe_i = 1'b0;

    // Reset state
    idle_cycles(3);
    check("rst_ack", wb.wb_ack_o, 1'b0);
    check("rst_stall", wb.wb_stall_o, 1'b0);
    check("rst_oe", ram_oe, 1'b0);
    check("rst_we", ram_we, 1'b0);
    check("rst_addr", ram_addr, 0);
    check("rst_ram_dout", ram_dout, 0);
    check("rst_wb_dout", wb.wb_data_o, 0);
    rst_n = 1'b1;
    idle_cycles(2);

    // First read with detailed timing: 0xA5 at 0x01234
    do_req(1'b0, 17'h01234, 8'h00, 1'b1);         // now after edge N
    check("rd_oe_after_accept", ram_oe, 1'b1);
    check("rd_addr_latched", ram_addr, 17'h01234);
    idle_cycles(3);                                // after N+3
    check("rd_oe_before_ack", ram_oe, 1'b1);
    check("rd_no_early_ack", wb.wb_ack_o, 1'b0);
    idle_cycles(1);                                // after N+4
    check("rd_ack_at_n4", wb.wb_ack_o, 1'b1);
    check("rd_oe_low_at_ack", ram_oe, 1'b0);
    check("rd_stall_in_recover", wb.wb_stall_o, 1'b1);
    idle_cycles(1);                                // after N+5
    check("rd_ack_single", wb.wb_ack_o, 1'b0);
    check("rd_idle_for_n6", wb.wb_stall_o, 1'b0);

    // Write to the top address, then read it back
    do_req(1'b1, 17'h1FFFF, 8'h5A, 1'b1);
    do_req(1'b0, 17'h1FFFF, 8'h00, 1'b1);

    // Back-to-back read then write to the same address, then readback
    do_req(1'b0, 17'h00200, 8'h00, 1'b1);
    do_req(1'b1, 17'h00200, 8'h77, 1'b1);
    do_req(1'b0, 17'h00200, 8'h00, 1'b1);

    // Abort mid-read: OE drops at the next edge, no ack
    do_req(1'b0, 17'h00345, 8'h00, 1'b0);
    idle_cycles(1);
    wb.wb_cycle_i = 1'b0;
    idle_cycles(1);
    check("abort_rd_oe_low", ram_oe, 1'b0);
    idle_cycles(8);
    wb.wb_cycle_i = 1'b1;

    // Abort mid-write: full WE pulse, no ack, cache entry dropped
    do_req(1'b1, 17'h00456, 8'hC3, 1'b0);
    wb.wb_cycle_i = 1'b0;
    idle_cycles(8);
    wb.wb_cycle_i = 1'b1;
    do_req(1'b0, 17'h00456, 8'h00, 1'b1);

`ifdef SRAM_CTL_RDCACHE_EN
    // Repeat read served from the cache: ack at N+1, no OE pulse
    do_req(1'b0, 17'h00010, 8'h00, 1'b1);
    idle_cycles(8);
    got = oe_rises;
    do_req(1'b0, 17'h00010, 8'h00, 1'b1);
    idle_cycles(3);
    check("cache_hit_no_oe", oe_rises - got, 0);
`endif

    // Randomized traffic over a small address set so locations repeat
    for (int i = 0; i < 150; i++) begin
      a = 17'h00100 + 17'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) a[16] = 1'b1;
      do_req(1'($urandom_range(0, 1)), a, 8'($urandom), 1'b1);
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
    end

    // Drain outstanding expectations
    got = 0;
    while (sb.size() != 0 && got < 200) begin
      @(negedge clk);
      got++;
    end
    check("scoreboard_drained", sb.size(), 0);

    // Reset mid-read: pins idle next cycle, no late ack
    do_req(1'b0, 17'h00567, 8'h00, 1'b0);
    idle_cycles(1);
    check("pre_reset_oe_high", ram_oe, 1'b1);
    rst_n = 1'b0;
    wb.wb_cycle_i = 1'b0;
    idle_cycles(1);
    check("reset_oe_low", ram_oe, 1'b0);
    check("reset_ack_low", wb.wb_ack_o, 1'b0);
    check("reset_stall_low", wb.wb_stall_o, 1'b0);
    c_valid = 1'b0;
    idle_cycles(2);
    rst_n = 1'b1;
    idle_cycles(8);

    // Address window on the second instance: 2'b10 ignored, 2'b01 served
    wb2.wb_addr_i = 17'h10000; wb2.wb_we_i = 1'b0;
    wb2.wb_cycle_i = 1'b1; wb2.wb_strobe_i = 1'b1;
    seen = 0; got = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (wb2.wb_ack_o) seen++;
      if (ram2_oe || ram2_we) got++;
    end
    check("unselected_no_ack", seen, 0);
    check("unselected_no_sram", got, 0);
    wb2.wb_addr_i = 17'h08010;
    t0 = cyc_cnt + 1;
    @(negedge clk);
    wb2.wb_strobe_i = 1'b0;
    got = 0;
    while (!wb2.wb_ack_o && got < 20) begin
      @(negedge clk);
      got++;
    end
    check("selected_ack_seen", wb2.wb_ack_o, 1'b1);
    check("selected_ack_latency", cyc_cnt - t0, RD);
    check("selected_read_data", wb2.wb_data_o, 8'h3C);
    wb2.wb_cycle_i = 1'b0;
    idle_cycles(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
